// File: rtl/descr_para_mon_if.sv
// Handshake/data bundle for the x^58+x^39+1 parallel descrambler.
// master drives the line side, slave is the descrambler.
interface descr_para_mon_if #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] DataIn;
  logic              DataInValid;
  logic              Resync;
  logic              Bypass;
  logic              REV;
  logic              CheckEn;
  logic              ErrClr;
  logic [DATA_W-1:0] DataOut;
  logic              DataOutValid;
  logic              Locked;
  logic [CNT_W-1:0]  ErrCnt;

  modport master (
    output DataIn, DataInValid, Resync,
    output Bypass, REV, CheckEn, ErrClr,
    input  DataOut, DataOutValid, Locked, ErrCnt
  );

  modport slave (
    input  DataIn, DataInValid, Resync,
    input  Bypass, REV, CheckEn, ErrClr,
    output DataOut, DataOutValid, Locked, ErrCnt
  );
endinterface

// File: rtl/descr_para_mon.sv
// Self-synchronising x^58+x^39+1 descrambler for parallel words,
// with warm-up suppression, bypass/invert and an idle-error monitor.
module descr_para_mon #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 16
) (
  input  logic            CLK,
  input  logic            RSTn,
  descr_para_mon_if.slave bus
);
  localparam int HW       = 58;
  localparam int EW       = DATA_W + HW;
  localparam int WARMUP_N = (HW + DATA_W - 1) / DATA_W;

  typedef enum logic {
    WARMUP,
    RUN
  } state_e;

  logic              rst_sync_q;
  logic              rst_n;
  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [HW-1:0]     hist_q, hist_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dov_q, dov_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic [EW-1:0]     ext;
  logic [DATA_W-1:0] desc;
  logic [HW-1:0]     hist_nx;
  logic              acc;
  logic              hit;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rst_sync_q <= 1'b0;
    else       rst_sync_q <= 1'b1;
  end

  assign rst_n = rst_sync_q;

  // ext is the time-ordered stream: history oldest-first, then the word.
  always_comb begin
    ext = '0;
    for (int k = 0; k < HW; k++)
      ext[HW-1-k] = hist_q[k];
    for (int i = 0; i < DATA_W; i++)
      ext[HW+i] = bus.DataIn[i];
  end

  always_comb begin
    desc = '0;
    for (int i = 0; i < DATA_W; i++)
      desc[i] = ext[HW+i] ^ ext[19+i] ^ ext[i];
  end

  always_comb begin
    hist_nx = '0;
    for (int k = 0; k < HW; k++)
      hist_nx[k] = ext[EW-1-k];
  end

  assign acc = bus.DataInValid & ~bus.Resync;
  assign hit = acc & bus.CheckEn & ~bus.Bypass
             & (state_q == RUN) & (|desc);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hist_d  = hist_q;
    dout_d  = dout_q;
    dov_d   = 1'b0;
    unique case (1'b1)
      bus.Resync: begin
        state_d = WARMUP;
        cnt_d   = '0;
        hist_d  = '0;
      end
      acc: begin
        hist_d = hist_nx;
        dout_d = (bus.Bypass ? bus.DataIn : desc)
               ^ {DATA_W{bus.REV}};
        if (state_q == RUN) begin
          dov_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_d == 6'(WARMUP_N))
            state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (bus.ErrClr)
      err_d = '0;
    else if (hit && (err_q != {CNT_W{1'b1}}))
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
      hist_q  <= '0;
      dout_q  <= '0;
      dov_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      dout_q  <= dout_d;
      dov_q   <= dov_d;
      err_q   <= err_d;
    end
  end

  assign bus.DataOut      = dout_q;
  assign bus.DataOutValid = dov_q;
  assign bus.Locked       = (state_q == RUN);
  assign bus.ErrCnt       = err_q;
endmodule
